// File: rtl/object_scheduler_if.sv
// Frame-control and playfield-position bundle between the game logic and the per-frame object scheduler.
interface object_scheduler_if;
    logic       FRAME_START;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       BTN_LEFT;
    logic       BTN_RIGHT;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] car_x;
    logic [9:0] car2_x;
    logic [9:0] car3_x;
    logic [9:0] car4_x;
    logic [1:0] lives;
    logic [3:0] score;
    logic       COLLISION;
    logic       GAME_OVER;
    logic       BUSY;

    modport master (
        output FRAME_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT,
        input  player_x, player_y, car_x, car2_x, car3_x, car4_x,
        input  lives, score, COLLISION, GAME_OVER, BUSY
    );

    modport slave (
        input  FRAME_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT,
        output player_x, player_y, car_x, car2_x, car3_x, car4_x,
        output lives, score, COLLISION, GAME_OVER, BUSY
    );
endinterface

// File: rtl/object_scheduler.sv
// Per-frame game-object scheduler: one player move, four car lane updates and an overlap check per vblank.
//
// state    | meaning
// S_IDLE   | waiting for FRAME_START
// S_PLAYER | apply one pending move, handle crossing
// S_CARS   | advance car idx_q (one per cycle)
// S_CHECK  | overlap test against car idx_q
// S_DONE   | apply collision, lives and spawn return
// S_OVER   | lives exhausted, everything frozen
module object_scheduler #(
    parameter int H_DISPLAY      = 640,
    parameter int V_DISPLAY      = 480,
    parameter int PLAYER_WIDTH   = 20,
    parameter int PLAYER_HEIGHT  = 20,
    parameter int PLAYER_STEP    = 20,
    parameter int PLAYER_START_X = 310,
    parameter int PLAYER_START_Y = 460,
    parameter int CAR_WIDTH      = 40,
    parameter int CAR_HEIGHT     = 20,
    parameter int CAR1_Y = 100, parameter int CAR2_Y = 180,
    parameter int CAR3_Y = 260, parameter int CAR4_Y = 340,
    parameter int CAR1_X0 = 0,   parameter int CAR2_X0 = 160,
    parameter int CAR3_X0 = 320, parameter int CAR4_X0 = 480,
    parameter int CAR1_SPEED = 1, parameter int CAR2_SPEED = 2,
    parameter int CAR3_SPEED = 3, parameter int CAR4_SPEED = 4
) (
    input logic               CLK,
    input logic               RST,
    object_scheduler_if.slave sched
);
    typedef enum logic [2:0] {S_IDLE, S_PLAYER, S_CARS, S_CHECK, S_DONE, S_OVER} state_t;

    localparam logic [10:0] P_STEP  = 11'(PLAYER_STEP);
    localparam logic [10:0] P_W     = 11'(PLAYER_WIDTH);
    localparam logic [10:0] P_H     = 11'(PLAYER_HEIGHT);
    localparam logic [10:0] P_XMAX  = 11'(H_DISPLAY - PLAYER_WIDTH);
    localparam logic [10:0] P_YMAX  = 11'(V_DISPLAY - PLAYER_HEIGHT);
    localparam logic [10:0] C_W     = 11'(CAR_WIDTH);
    localparam logic [10:0] C_H     = 11'(CAR_HEIGHT);
    localparam logic [10:0] C_XMAX  = 11'(H_DISPLAY - CAR_WIDTH);
    localparam logic [9:0]  SPAWN_X = 10'(PLAYER_START_X);
    localparam logic [9:0]  SPAWN_Y = 10'(PLAYER_START_Y);
    localparam logic [3:0][9:0] CAR_Y  = {10'(CAR4_Y), 10'(CAR3_Y), 10'(CAR2_Y), 10'(CAR1_Y)};
    localparam logic [3:0][9:0] CAR_X0 = {10'(CAR4_X0), 10'(CAR3_X0), 10'(CAR2_X0), 10'(CAR1_X0)};
    localparam logic [3:0][3:0] CAR_SPD = {4'(CAR4_SPEED), 4'(CAR3_SPEED), 4'(CAR2_SPEED), 4'(CAR1_SPEED)};

    state_t          state_q;
    logic [1:0]      idx_q;
    logic [3:0][9:0] car_x_q;
    logic [9:0]      px_q, py_q;
    logic [1:0]      lives_q;
    logic [3:0]      score_q;
    logic            col_q, over_q, busy_q, hit_q;
    logic [3:0]      btn_q, pend_q;

    logic [3:0]  btn_d, rise_d;
    logic [10:0] px11, py11, cx11, cy11, spd11, sum11;
    logic [9:0]  car_nx_d, nx_d, ny_d;
    logic        hit_d;

    // bit order: 0 up, 1 down, 2 left, 3 right (also the move priority)
    assign btn_d  = {sched.BTN_RIGHT, sched.BTN_LEFT, sched.BTN_DOWN, sched.BTN_UP};
    assign rise_d = btn_d & ~btn_q;

    always_comb begin
        px11  = {1'b0, px_q};
        py11  = {1'b0, py_q};
        cx11  = {1'b0, car_x_q[idx_q]};
        cy11  = {1'b0, CAR_Y[idx_q]};
        spd11 = {7'd0, CAR_SPD[idx_q]};
        sum11 = cx11 + spd11;
        car_nx_d = car_x_q[idx_q];
        if (!idx_q[0]) begin
            car_nx_d = (sum11 > C_XMAX) ? 10'd0 : sum11[9:0];
        end else begin
            car_nx_d = (cx11 < spd11) ? C_XMAX[9:0] : 10'(cx11 - spd11);
        end
        hit_d = (px11 < cx11 + C_W) && (cx11 < px11 + P_W) &&
                (py11 < cy11 + C_H) && (cy11 < py11 + P_H);
        nx_d = px_q;
        ny_d = py_q;
        if (pend_q[0]) begin
            if (py11 >= P_STEP) ny_d = 10'(py11 - P_STEP);
        end else if (pend_q[1]) begin
            if (py11 + P_STEP <= P_YMAX) ny_d = 10'(py11 + P_STEP);
        end else if (pend_q[2]) begin
            if (px11 >= P_STEP) nx_d = 10'(px11 - P_STEP);
        end else if (pend_q[3]) begin
            if (px11 + P_STEP <= P_XMAX) nx_d = 10'(px11 + P_STEP);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            car_x_q <= CAR_X0;
            px_q    <= SPAWN_X;
            py_q    <= SPAWN_Y;
            lives_q <= 2'd3;
            score_q <= 4'd0;
            col_q   <= 1'b0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            btn_q   <= 4'd0;
            pend_q  <= 4'd0;
        end else begin
            btn_q  <= btn_d;
            pend_q <= (state_q == S_PLAYER) ? rise_d : (pend_q | rise_d);
            col_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sched.FRAME_START) begin
                        state_q <= S_PLAYER;
                        busy_q  <= 1'b1;
                        hit_q   <= 1'b0;
                    end
                end
                S_PLAYER: begin
                    if (ny_d == 10'd0) begin
                        score_q <= (score_q == 4'd15) ? score_q : score_q + 4'd1;
                        px_q    <= SPAWN_X;
                        py_q    <= SPAWN_Y;
                    end else begin
                        px_q <= nx_d;
                        py_q <= ny_d;
                    end
                    idx_q   <= 2'd0;
                    state_q <= S_CARS;
                end
                S_CARS: begin
                    car_x_q[idx_q] <= car_nx_d;
                    idx_q          <= idx_q + 2'd1;
                    if (idx_q == 2'd3) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    hit_q <= hit_q | hit_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (hit_q) begin
                        col_q   <= 1'b1;
                        lives_q <= lives_q - 2'd1;
                        px_q    <= SPAWN_X;
                        py_q    <= SPAWN_Y;
                        if (lives_q == 2'd1) begin
                            over_q  <= 1'b1;
                            state_q <= S_OVER;
                        end
                    end
                end
                S_OVER: begin
                    over_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sched.player_x  = px_q;
    assign sched.player_y  = py_q;
    assign sched.car_x     = car_x_q[0];
    assign sched.car2_x    = car_x_q[1];
    assign sched.car3_x    = car_x_q[2];
    assign sched.car4_x    = car_x_q[3];
    assign sched.lives     = lives_q;
    assign sched.score     = score_q;
    assign sched.COLLISION = col_q;
    assign sched.GAME_OVER = over_q;
    assign sched.BUSY      = busy_q;
endmodule

// File: tb/tb_object_scheduler.sv
// Randomized self-checking bench for object_scheduler against a frame-level behavioural model.
module tb_object_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    object_scheduler_if sif ();

    object_scheduler dut (.CLK(clk), .RST(rst), .sched(sif));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state (pixel units, plain ints)
    int m_px, m_py, m_lives, m_score, m_over, m_crossings;
    int m_cx[4];
    logic [3:0] m_pend;
    int spd[4]   = '{1, 2, 3, 4};
    int lane_y[4] = '{100, 180, 260, 340};
    int x0[4]    = '{0, 160, 320, 480};

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int car_step(int i, int x);
        if (i % 2 == 0) return (x + spd[i] > 600) ? 0 : x + spd[i];
        return (x < spd[i]) ? 600 : x - spd[i];
    endfunction

    function automatic bit overlap(int px, int py, int cx, int cy);
        return (px < cx + 40) && (cx < px + 20) && (py < cy + 20) && (cy < py + 20);
    endfunction

    function automatic bit would_hit(int px, int py);
        bit h = 0;
        for (int i = 0; i < 4; i++) h |= overlap(px, py, car_step(i, m_cx[i]), lane_y[i]);
        return h;
    endfunction

    task automatic model_reset();
        m_px = 310; m_py = 460; m_lives = 3; m_score = 0; m_over = 0; m_pend = 4'd0;
        for (int i = 0; i < 4; i++) m_cx[i] = x0[i];
    endtask

    task automatic model_frame(input logic [3:0] late, output int col);
        bit hit = 0;
        col = 0;
        if (m_over != 0) return;
        if (m_pend[0]) begin if (m_py >= 20) m_py -= 20; end
        else if (m_pend[1]) begin if (m_py + 20 <= 460) m_py += 20; end
        else if (m_pend[2]) begin if (m_px >= 20) m_px -= 20; end
        else if (m_pend[3]) begin if (m_px + 20 <= 620) m_px += 20; end
        m_pend = late;
        if (m_py == 0) begin
            m_crossings++;
            if (m_score < 15) m_score++;
            m_px = 310; m_py = 460;
        end
        for (int i = 0; i < 4; i++) m_cx[i] = car_step(i, m_cx[i]);
        for (int i = 0; i < 4; i++) hit |= overlap(m_px, m_py, m_cx[i], lane_y[i]);
        if (hit) begin
            col = 1; m_lives--; m_px = 310; m_py = 460;
            if (m_lives == 0) m_over = 1;
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        sif.BTN_UP = m[0]; sif.BTN_DOWN = m[1]; sif.BTN_LEFT = m[2]; sif.BTN_RIGHT = m[3];
    endtask

    task automatic compare_state();
        chk("player_x", int'(sif.player_x), m_px);
        chk("player_y", int'(sif.player_y), m_py);
        chk("car1_x", int'(sif.car_x), m_cx[0]);
        chk("car2_x", int'(sif.car2_x), m_cx[1]);
        chk("car3_x", int'(sif.car3_x), m_cx[2]);
        chk("car4_x", int'(sif.car4_x), m_cx[3]);
        chk("lives", int'(sif.lives), m_lives);
        chk("score", int'(sif.score), m_score);
        chk("game_over", int'(sif.GAME_OVER), m_over);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_btns(4'd0);
        sif.FRAME_START = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input logic [3:0] m);
        @(posedge clk); #1 set_btns(m);
        @(posedge clk); #1 set_btns(4'd0);
        m_pend |= m;
    endtask

    task automatic run_frame(input logic [3:0] late);
        int busy_cnt, exp_busy, col_exp;
        exp_busy = (m_over != 0) ? 0 : 10;
        @(posedge clk); #1 sif.FRAME_START = 1'b1;
        @(posedge clk); #1 sif.FRAME_START = 1'b0;
        if (m_over == 0) set_btns(late);
        busy_cnt = 0;
        while (sif.BUSY && busy_cnt < 30) begin
            busy_cnt++;
            @(posedge clk); #1 set_btns(4'd0);
        end
        set_btns(4'd0);
        chk("busy_cycles", busy_cnt, exp_busy);
        model_frame((m_over != 0) ? 4'd0 : late, col_exp);
        chk("collision", int'(sif.COLLISION), col_exp);
        compare_state();
        @(posedge clk); #1;
        chk("collision_drop", int'(sif.COLLISION), 0);
    endtask

    initial begin
        logic [3:0] m, late;
        int guard;
        sif.FRAME_START = 1'b0;
        set_btns(4'd0);
        m_crossings = 0;

        do_reset();
        compare_state();
        chk("reset_busy", int'(sif.BUSY), 0);
        chk("reset_collision", int'(sif.COLLISION), 0);

        run_frame(4'd0);
        chk("f1_car1", int'(sif.car_x), 1);
        chk("f1_car2", int'(sif.car2_x), 158);
        chk("f1_car3", int'(sif.car3_x), 323);
        chk("f1_car4", int'(sif.car4_x), 476);

        press(4'b0101);
        run_frame(4'd0);
        chk("upleft_y", int'(sif.player_y), 440);
        chk("upleft_x", int'(sif.player_x), 310);
        run_frame(4'd0);
        chk("nopress_y", int'(sif.player_y), 440);

        do_reset();
        press(4'b0010);
        run_frame(4'd0);
        chk("down_blocked", int'(sif.player_y), 460);
        for (int i = 0; i < 16; i++) begin
            press(4'b0100);
            run_frame(4'd0);
        end
        chk("left_blocked", int'(sif.player_x), 10);

        // idle frames long enough for every lane to wrap at least once
        do_reset();
        for (int i = 0; i < 610; i++) run_frame(4'd0);

        // dodge: only step up when the model predicts no hit
        do_reset();
        m_crossings = 0;
        guard = 0;
        while (m_crossings < 17 && guard < 1500) begin
            guard++;
            if ($urandom_range(0, 9) != 0 && !would_hit(m_px, m_py - 20)) press(4'b0001);
            run_frame(4'd0);
        end
        chk("crossings_reached", (m_crossings >= 17) ? 1 : 0, 1);
        chk("score_saturated", int'(sif.score), 15);

        // reckless: mostly up, random extra and in-sequence presses until game over
        guard = 0;
        while (m_over == 0 && guard < 600) begin
            guard++;
            m = ($urandom_range(0, 4) != 0) ? 4'b0001 : 4'($urandom_range(1, 15));
            late = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (m_pend == 4'd0) press(m);
            run_frame(late);
        end
        chk("game_over_reached", int'(sif.GAME_OVER), 1);
        for (int i = 0; i < 3; i++) begin
            press(4'b0001);
            run_frame(4'd0);
        end

        // reset in the middle of a sequence discards the partial update
        do_reset();
        @(posedge clk); #1 sif.FRAME_START = 1'b1;
        @(posedge clk); #1 sif.FRAME_START = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", int'(sif.BUSY), 0);
        chk("midrst_car1", int'(sif.car_x), 0);
        chk("midrst_car2", int'(sif.car2_x), 160);
        chk("midrst_car3", int'(sif.car3_x), 320);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
